// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its pipeline register.
package fetch_stage_pkg;

   localparam int XLEN = 32;

   // IF/ID register control from the hazard detector
   typedef enum logic [1:0] {
      GO    = 2'b00,
      HOLD  = 2'b01,
      FLUSH = 2'b10
   } if_id_ctrl_e;

   // DLX NOP, shared with the ID/EX flush logic
   localparam logic [XLEN-1:0] NOP = 32'h5400_0000;

   // Fetch FSM: REQ issues fetches, DRAIN waits out a request abandoned by a redirect
   typedef enum logic {
      FS_REQ   = 1'b0,
      FS_DRAIN = 1'b1
   } fetch_state_e;

   // Force an address onto a word boundary
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if
   import fetch_stage_pkg::*;
   ();
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [XLEN-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// GO/HOLD/FLUSH pipeline register carrying instruction, PC+4 and valid.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int DATA_W = XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ctrl,
   input  logic [DATA_W-1:0] d_instr,
   input  logic [DATA_W-1:0] d_pc4,
   input  logic              d_valid,
   output logic [DATA_W-1:0] q_instr,
   output logic [DATA_W-1:0] q_pc4,
   output logic              q_valid
);

   // GO loads, FLUSH inserts a bubble, anything else holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_instr <= DATA_W'(NOP);
         q_pc4   <= '0;
      end else begin
         case (ctrl)
            GO: begin
               q_valid <= d_valid;
               q_instr <= d_instr;
               q_pc4   <= d_pc4;
            end
            FLUSH: begin
               q_valid <= 1'b0;
               q_instr <= DATA_W'(NOP);
               q_pc4   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory handshake, one-word holding buffer, IF/ID register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              DATA_W   = XLEN,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_enable,
   input  logic [1:0]        if_id_ctrl,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   fetch_stage_if.master     imem,
   output logic [XLEN-1:0]   id_instr,
   output logic [XLEN-1:0]   id_pc4,
   output logic              id_valid
);

   fetch_state_e    state, state_nxt;
   logic [XLEN-1:0] pc, pc4, pc_nxt, req_addr;
   logic            hb_valid;
   logic [XLEN-1:0] hb_instr, hb_pc4;
   logic            req_pending, adv, mem_word, word_avail, buf_store;
   logic [XLEN-1:0] word_instr, word_pc4;
   logic [1:0]      reg_ctrl;
   logic [XLEN-1:0] d_instr, d_pc4;
   logic            d_valid;

   assign pc4        = pc + XLEN'(4);
   assign adv        = pc_enable && (if_id_ctrl == GO) && !redirect_valid;
   // Memory data only counts when it answers a live REQ-state fetch
   assign mem_word   = (state == FS_REQ) && !hb_valid && imem.imem_ready;
   assign word_avail = hb_valid || mem_word;
   assign word_instr = hb_valid ? hb_instr : imem.imem_rdata;
   assign word_pc4   = hb_valid ? hb_pc4 : pc4;
   assign buf_store  = mem_word && !adv && !redirect_valid;
   assign pc_nxt     = redirect_valid ? word_align(redirect_pc) :
                       (adv && word_avail) ? pc4 : pc;

   assign imem.imem_req  = req_pending && !rst;
   assign imem.imem_addr = req_addr;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FS_REQ;
      else     state <= state_nxt;
   end

   // FSM next state and request strobe
   always_comb begin
      state_nxt   = state;
      req_pending = 1'b0;
      case (state)
         FS_REQ: begin
            req_pending = !hb_valid;
            if (redirect_valid && req_pending && !imem.imem_ready) state_nxt = FS_DRAIN;
         end
         FS_DRAIN: begin
            req_pending = 1'b1;
            if (imem.imem_ready) state_nxt = FS_REQ;
         end
         default: state_nxt = FS_REQ;
      endcase
   end

   // PC, fetch address and buffer occupancy; the address freezes while a request waits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         hb_valid <= 1'b0;
      end else begin
         pc <= pc_nxt;
         if (!(req_pending && !imem.imem_ready)) req_addr <= pc_nxt;
         if (redirect_valid)          hb_valid <= 1'b0;
         else if (hb_valid && adv)    hb_valid <= 1'b0;
         else if (buf_store)          hb_valid <= 1'b1;
      end
   end

   // Holding-buffer payload for a word that arrived while decode was stalled
   always_ff @(posedge clk) begin
      if (buf_store) begin
         hb_instr <= imem.imem_rdata;
         hb_pc4   <= pc4;
      end
   end

   // IF/ID control: redirect or flush bubbles, stall holds, advance loads word or bubble
   always_comb begin
      reg_ctrl = HOLD;
      d_instr  = NOP;
      d_pc4    = '0;
      d_valid  = 1'b0;
      if (redirect_valid || if_id_ctrl == FLUSH) begin
         reg_ctrl = FLUSH;
      end else if (adv) begin
         reg_ctrl = GO;
         if (word_avail) begin
            d_instr = word_instr;
            d_pc4   = word_pc4;
            d_valid = 1'b1;
         end
      end
   end

   if_id_reg #(.DATA_W(XLEN)) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .ctrl    (reg_ctrl),
      .d_instr (d_instr),
      .d_pc4   (d_pc4),
      .d_valid (d_valid),
      .q_instr (id_instr),
      .q_pc4   (id_pc4),
      .q_valid (id_valid)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed timing scenarios plus a randomized stream check.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_enable;
   logic [1:0]  if_id_ctrl;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] id_instr, id_pc4;
   logic        id_valid;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] key = 32'h0;

   fetch_stage_if imem_bus ();

   fetch_stage #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_enable      (pc_enable),
      .if_id_ctrl     (if_id_ctrl),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem_bus),
      .id_instr       (id_instr),
      .id_pc4         (id_pc4),
      .id_valid       (id_valid)
   );

   always #5 clk = ~clk;

   logic [64:0] id_vec;
   logic [32:0] bus_vec;
   assign id_vec  = {id_valid, id_pc4, id_instr};
   assign bus_vec = {imem_bus.imem_req, imem_bus.imem_addr};

   // Memory answers with addr ^ key, so every word identifies its own address
   task automatic set_in(input logic pe, input logic [1:0] ctl, input logic rv,
                         input logic [31:0] rpc, input logic rdy);
      pc_enable           = pe;
      if_id_ctrl          = ctl;
      redirect_valid      = rv;
      redirect_pc         = rpc;
      imem_bus.imem_ready = rdy;
      imem_bus.imem_rdata = imem_bus.imem_addr ^ key;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, GO, 1'b0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (bus_vec !== {1'b0, RESET_PC}) begin
         errors++; $display("FAIL reset_bus got=%h exp=%h", bus_vec, {1'b0, RESET_PC});
      end
      checks++;
      if (id_vec !== {1'b0, 32'h0, NOP}) begin
         errors++; $display("FAIL reset_id got=%h exp=%h", id_vec, {1'b0, 32'h0, NOP});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus_vec !== {1'b1, RESET_PC}) begin
         errors++; $display("FAIL reset_first_req got=%h exp=%h", bus_vec, {1'b1, RESET_PC});
      end
      next_cycle();
   endtask

   task automatic test_stream();
      key = 32'h0;
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
         @(negedge clk);
         checks++;
         if (bus_vec !== {1'b1, 32'(4 * k)}) begin
            errors++; $display("FAIL stream_bus[%0d] got=%h exp=%h", k, bus_vec, {1'b1, 32'(4 * k)});
         end
         checks++;
         if (k == 0) begin
            if (id_valid !== 1'b0) begin
               errors++; $display("FAIL stream_first_valid got=%b exp=0", id_valid);
            end
         end else if (id_vec !== {1'b1, 32'(4 * k), 32'(4 * k - 4)}) begin
            errors++; $display("FAIL stream_id[%0d] got=%h exp=%h", k, id_vec, {1'b1, 32'(4 * k), 32'(4 * k - 4)});
         end
         next_cycle();
      end
   endtask

   task automatic test_hold();
      key = 32'h0;
      apply_reset();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      next_cycle();
      // first stall cycle: word 8 arrives and must be parked
      set_in(1'b0, HOLD, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus_vec !== {1'b1, 32'h8} || id_vec !== {1'b1, 32'h8, 32'h4}) begin
         errors++; $display("FAIL hold_c1 got=%h/%h exp=%h/%h", bus_vec, id_vec, {1'b1, 32'h8}, {1'b1, 32'h8, 32'h4});
      end
      next_cycle();
      set_in(1'b0, HOLD, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (imem_bus.imem_req !== 1'b0 || id_vec !== {1'b1, 32'h8, 32'h4}) begin
         errors++; $display("FAIL hold_c2 got=%b/%h exp=0/%h", imem_bus.imem_req, id_vec, {1'b1, 32'h8, 32'h4});
      end
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (imem_bus.imem_req !== 1'b0 || id_vec !== {1'b1, 32'h8, 32'h4}) begin
         errors++; $display("FAIL hold_release got=%b/%h exp=0/%h", imem_bus.imem_req, id_vec, {1'b1, 32'h8, 32'h4});
      end
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus_vec !== {1'b1, 32'hC} || id_vec !== {1'b1, 32'hC, 32'h8}) begin
         errors++; $display("FAIL hold_resume got=%h/%h exp=%h/%h", bus_vec, id_vec, {1'b1, 32'hC}, {1'b1, 32'hC, 32'h8});
      end
      next_cycle();
   endtask

   task automatic test_wait_states();
      key = 32'h1234_0000;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
         next_cycle();
      end
      for (int w = 0; w < 4; w++) begin
         set_in(1'b1, GO, 1'b0, 32'h0, (w == 3));
         @(negedge clk);
         checks++;
         if (bus_vec !== {1'b1, 32'h10}) begin
            errors++; $display("FAIL wait_bus[%0d] got=%h exp=%h", w, bus_vec, {1'b1, 32'h10});
         end
         checks++;
         if (w == 0) begin
            if (id_vec !== {1'b1, 32'h10, 32'hC ^ key}) begin
               errors++; $display("FAIL wait_id0 got=%h exp=%h", id_vec, {1'b1, 32'h10, 32'hC ^ key});
            end
         end else if (id_valid !== 1'b0) begin
            errors++; $display("FAIL wait_bubble[%0d] got=%b exp=0", w, id_valid);
         end
         next_cycle();
      end
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (id_vec !== {1'b1, 32'h14, 32'h10 ^ key} || bus_vec !== {1'b1, 32'h14}) begin
         errors++; $display("FAIL wait_done got=%h/%h exp=%h/%h", id_vec, bus_vec, {1'b1, 32'h14, 32'h10 ^ key}, {1'b1, 32'h14});
      end
      next_cycle();
   endtask

   task automatic test_redirect();
      key = 32'h00C0_FFEE;
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
         next_cycle();
      end
      set_in(1'b1, GO, 1'b1, 32'h100, 1'b0);
      @(negedge clk);
      checks++;
      if (bus_vec !== {1'b1, 32'h20} || id_vec !== {1'b1, 32'h20, 32'h1C ^ key}) begin
         errors++; $display("FAIL redir_issue got=%h/%h exp=%h/%h", bus_vec, id_vec, {1'b1, 32'h20}, {1'b1, 32'h20, 32'h1C ^ key});
      end
      next_cycle();
      for (int d = 0; d < 2; d++) begin
         set_in(1'b1, GO, 1'b0, 32'h0, (d == 1));
         @(negedge clk);
         checks++;
         if (bus_vec !== {1'b1, 32'h20} || id_valid !== 1'b0 || id_instr !== NOP) begin
            errors++; $display("FAIL redir_drain[%0d] got=%h/%h exp=%h/bubble", d, bus_vec, id_vec, {1'b1, 32'h20});
         end
         next_cycle();
      end
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus_vec !== {1'b1, 32'h100} || id_valid !== 1'b0) begin
         errors++; $display("FAIL redir_target_req got=%h/%b exp=%h/0", bus_vec, id_valid, {1'b1, 32'h100});
      end
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (id_vec !== {1'b1, 32'h104, 32'h100 ^ key}) begin
         errors++; $display("FAIL redir_first_instr got=%h exp=%h", id_vec, {1'b1, 32'h104, 32'h100 ^ key});
      end
      next_cycle();
   endtask

   task automatic test_flush();
      key = 32'h0F0F_0000;
      apply_reset();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      next_cycle();
      set_in(1'b1, FLUSH, 1'b0, 32'h0, 1'b1);
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b0 || id_instr !== NOP) begin
         errors++; $display("FAIL flush_bubble got=%b/%h exp=0/%h", id_valid, id_instr, NOP);
      end
      checks++;
      if (bus_vec !== {1'b0, 32'h8}) begin
         errors++; $display("FAIL flush_pc_held got=%h exp=%h", bus_vec, {1'b0, 32'h8});
      end
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (id_vec !== {1'b1, 32'hC, 32'h8 ^ key} || bus_vec !== {1'b1, 32'hC}) begin
         errors++; $display("FAIL flush_resume got=%h/%h exp=%h/%h", id_vec, bus_vec, {1'b1, 32'hC, 32'h8 ^ key}, {1'b1, 32'hC});
      end
      next_cycle();
   endtask

   task automatic test_async_reset();
      key = 32'h0;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
         next_cycle();
      end
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus_vec !== {1'b0, RESET_PC} || id_vec !== {1'b0, 32'h0, NOP}) begin
         errors++; $display("FAIL async_reset got=%h/%h exp=%h/%h", bus_vec, id_vec, {1'b0, RESET_PC}, {1'b0, 32'h0, NOP});
      end
      next_cycle();
      rst = 1'b0;
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus_vec !== {1'b1, RESET_PC}) begin
         errors++; $display("FAIL async_restart got=%h exp=%h", bus_vec, {1'b1, RESET_PC});
      end
      next_cycle();
      set_in(1'b1, GO, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      checks++;
      if (id_vec !== {1'b1, RESET_PC + 32'd4, RESET_PC ^ key}) begin
         errors++; $display("FAIL async_first_instr got=%h exp=%h", id_vec, {1'b1, RESET_PC + 32'd4, RESET_PC ^ key});
      end
      next_cycle();
   endtask

   // Stream-level reference: valid instructions follow program order from the last redirect
   task automatic test_random();
      logic [31:0] exp_pc, rpc, p_rpc;
      logic        pe, rv, rdy, p_pe, p_rv, p_rdy, first;
      logic [1:0]  ctl, p_ctl;
      logic [64:0] p_id;
      logic [32:0] p_bus;
      int          r, delivered;
      key       = $urandom;
      apply_reset();
      exp_pc    = RESET_PC;
      first     = 1'b1;
      delivered = 0;
      p_pe = 1'b0; p_rv = 1'b0; p_rdy = 1'b0; p_ctl = GO; p_rpc = 32'h0; p_id = '0; p_bus = '0;
      for (int n = 0; n < 800; n++) begin
         pe  = ($urandom_range(0, 7) != 0);
         r   = int'($urandom_range(0, 19));
         ctl = (r == 0) ? FLUSH : (r < 3) ? HOLD : GO;
         rv  = ($urandom_range(0, 15) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                           : 32'($urandom_range(0, 16'hFFFF));
         rdy = imem_bus.imem_req ? ($urandom_range(0, 3) != 0) : 1'b0;
         set_in(pe, ctl, rv, rpc, rdy);
         @(negedge clk);
         if (!first) begin
            checks++;
            if (p_rv || p_ctl == FLUSH) begin
               if (id_valid !== 1'b0 || id_instr !== NOP) begin
                  errors++; $display("FAIL rnd_bubble[%0d] got=%h exp=bubble", n, id_vec);
               end
            end else if (p_ctl == GO && p_pe) begin
               if (id_valid === 1'b1) begin
                  if (id_vec !== {1'b1, exp_pc + 32'd4, exp_pc ^ key}) begin
                     errors++; $display("FAIL rnd_order[%0d] got=%h exp=%h", n, id_vec, {1'b1, exp_pc + 32'd4, exp_pc ^ key});
                  end
                  exp_pc    = exp_pc + 32'd4;
                  delivered++;
               end else if (id_instr !== NOP) begin
                  errors++; $display("FAIL rnd_nop[%0d] got=%h exp=%h", n, id_instr, NOP);
               end
            end else if (id_vec !== p_id) begin
               errors++; $display("FAIL rnd_hold[%0d] got=%h exp=%h", n, id_vec, p_id);
            end
            if (p_rv) exp_pc = p_rpc & ~32'd3;
            if (p_bus[32] && !p_rdy) begin
               checks++;
               if (bus_vec !== p_bus) begin
                  errors++; $display("FAIL rnd_addr_stable[%0d] got=%h exp=%h", n, bus_vec, p_bus);
               end
            end
         end
         checks++;
         if (imem_bus.imem_addr[1:0] !== 2'b00) begin
            errors++; $display("FAIL rnd_align[%0d] got=%h exp=word aligned", n, imem_bus.imem_addr);
         end
         p_pe = pe; p_ctl = ctl; p_rv = rv; p_rpc = rpc; p_rdy = rdy;
         p_id = id_vec; p_bus = bus_vec; first = 1'b0;
         next_cycle();
      end
      checks++;
      if (delivered < 100) begin
         errors++; $display("FAIL rnd_progress got=%0d exp>=100", delivered);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_wait_states();
      test_redirect();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
